// File: rtl/uart_cmd_decoder.sv
// Host command decoder: frames HDR,CMD,P2,P1,P0[,CHK] from uart_rx, updates ADC config and answers ACK/NAK.
// Optional CHK byte enabled by CMD_CHECKSUM_EN; response leaves >=3 cycles after the last byte, waits on tx_rdy.
module uart_cmd_decoder #(
    parameter int          N_NOWA        = 9,
    parameter int          N_NSAMP       = 18,
    parameter int          NSAMP_DEFAULT = 102400,
    parameter int          TIMEOUT_CYC   = 50000,
    parameter int          RST_PULSE_CYC = 16,
    parameter logic [7:0]  HDR           = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_vld,
    input  logic               tx_rdy,
    output logic               tx_wreq,
    output logic [7:0]         tx_wdata,
    input  logic               busy,
    output logic [N_NOWA-1:0]  nowa_cfg,
    output logic [N_NSAMP-1:0] nsamp_cfg,
    output logic               calib_ena,
    output logic               start_pulse,
    output logic               adc_srst,
    output logic               frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int SW = $clog2(RST_PULSE_CYC + 1);

`ifdef CMD_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_P2, S_P1, S_P0, S_CHK, S_EXEC, S_RESP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_P2, S_P1, S_P0, S_EXEC, S_RESP} state_t;
`endif

    state_t             state_q, state_d;
    logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [SW-1:0]      srst_cnt_q, srst_cnt_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [23:0]        pay_q, pay_d;
    logic [7:0]         resp_q, resp_d;
    logic               tx_wreq_q, tx_wreq_d;
    logic [7:0]         tx_wdata_q, tx_wdata_d;
    logic [N_NOWA-1:0]  nowa_q, nowa_d;
    logic [N_NSAMP-1:0] nsamp_q, nsamp_d;
    logic               calib_q, calib_d;
    logic               start_q, start_d;
    logic               ferr_q, ferr_d;
    logic               in_frame;
    logic               ack;
    logic               chk_bad;
    logic               unused_pay;

`ifdef CMD_CHECKSUM_EN
    logic chk_ok_q, chk_ok_d;
    assign chk_bad = !chk_ok_q;
`else
    assign chk_bad = 1'b0;
`endif

    // Wide payload is kept whole; bits above each field width are ignored by design
    assign unused_pay = ^pay_q;

    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        srst_cnt_d = (srst_cnt_q != '0) ? srst_cnt_q - 1'b1 : '0;
        cmd_d      = cmd_q;
        pay_d      = pay_q;
        resp_d     = resp_q;
        tx_wreq_d  = 1'b0;
        tx_wdata_d = tx_wdata_q;
        nowa_d     = nowa_q;
        nsamp_d    = nsamp_q;
        calib_d    = calib_q;
        start_d    = 1'b0;
        ferr_d     = 1'b0;
        ack        = 1'b1;
`ifdef CMD_CHECKSUM_EN
        chk_ok_d   = chk_ok_q;
        in_frame   = (state_q inside {S_CMD, S_P2, S_P1, S_P0, S_CHK});
`else
        in_frame   = (state_q inside {S_CMD, S_P2, S_P1, S_P0});
`endif

        if (in_frame) begin
            if (rx_vld) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                tmo_cnt_d = '0;
                state_d   = S_IDLE;
                ferr_d    = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: if (rx_vld && rx_data == HDR) begin
                state_d   = S_CMD;
                tmo_cnt_d = '0;
            end
            S_CMD: if (rx_vld) begin
                cmd_d   = rx_data;
                state_d = S_P2;
            end
            S_P2: if (rx_vld) begin
                pay_d[23:16] = rx_data;
                state_d      = S_P1;
            end
            S_P1: if (rx_vld) begin
                pay_d[15:8] = rx_data;
                state_d     = S_P0;
            end
`ifdef CMD_CHECKSUM_EN
            S_P0: if (rx_vld) begin
                pay_d[7:0] = rx_data;
                state_d    = S_CHK;
            end
            S_CHK: if (rx_vld) begin
                chk_ok_d = (rx_data == (cmd_q ^ pay_q[23:16] ^ pay_q[15:8] ^ pay_q[7:0]));
                state_d  = S_EXEC;
            end
`else
            S_P0: if (rx_vld) begin
                pay_d[7:0] = rx_data;
                state_d    = S_EXEC;
            end
`endif
            S_EXEC: begin
                if (chk_bad) begin
                    ack    = 1'b0;
                    ferr_d = 1'b1;
                end else begin
                    case (cmd_q)
                        8'h01: nowa_d = pay_q[N_NOWA-1:0];
                        8'h02: if (pay_q[N_NSAMP-1:0] == '0 || busy) ack = 1'b0;
                               else nsamp_d = pay_q[N_NSAMP-1:0];
                        8'h03: if (busy) ack = 1'b0;
                               else calib_d = pay_q[0];
                        8'h04: if (busy) ack = 1'b0;
                               else start_d = 1'b1;
                        8'h05: srst_cnt_d = SW'(RST_PULSE_CYC);
                        default: begin
                            ack    = 1'b0;
                            ferr_d = 1'b1;
                        end
                    endcase
                end
                resp_d  = ack ? (cmd_q | 8'h80) : 8'hEE;
                state_d = S_RESP;
            end
            S_RESP: if (tx_rdy) begin
                tx_wreq_d  = 1'b1;
                tx_wdata_d = resp_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tmo_cnt_q  <= '0;
            srst_cnt_q <= '0;
            cmd_q      <= '0;
            pay_q      <= '0;
            resp_q     <= '0;
            tx_wreq_q  <= 1'b0;
            tx_wdata_q <= '0;
            nowa_q     <= '0;
            nsamp_q    <= N_NSAMP'(NSAMP_DEFAULT);
            calib_q    <= 1'b0;
            start_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            chk_ok_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            srst_cnt_q <= srst_cnt_d;
            cmd_q      <= cmd_d;
            pay_q      <= pay_d;
            resp_q     <= resp_d;
            tx_wreq_q  <= tx_wreq_d;
            tx_wdata_q <= tx_wdata_d;
            nowa_q     <= nowa_d;
            nsamp_q    <= nsamp_d;
            calib_q    <= calib_d;
            start_q    <= start_d;
            ferr_q     <= ferr_d;
`ifdef CMD_CHECKSUM_EN
            chk_ok_q   <= chk_ok_d;
`endif
        end
    end

    assign tx_wreq     = tx_wreq_q;
    assign tx_wdata    = tx_wdata_q;
    assign nowa_cfg    = nowa_q;
    assign nsamp_cfg   = nsamp_q;
    assign calib_ena   = calib_q;
    assign start_pulse = start_q;
    assign adc_srst    = (srst_cnt_q != '0);
    assign frame_err   = ferr_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: response bytes checked through an expected-byte queue.
module tb_uart_cmd_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_vld = 1'b0;
    logic        tx_rdy = 1'b1;
    logic        busy = 1'b0;
    logic        tx_wreq;
    logic [7:0]  tx_wdata;
    logic [8:0]  nowa_cfg;
    logic [17:0] nsamp_cfg;
    logic        calib_ena, start_pulse, adc_srst, frame_err;

    int total = 0;
    int bad = 0;
    int wreq_cnt = 0;
    int start_cnt = 0;
    int ferr_cnt = 0;
    int srst_cnt = 0;
    logic [7:0] exp_q[$];

    uart_cmd_decoder dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld), .tx_rdy(tx_rdy),
        .tx_wreq(tx_wreq), .tx_wdata(tx_wdata), .busy(busy), .nowa_cfg(nowa_cfg),
        .nsamp_cfg(nsamp_cfg), .calib_ena(calib_ena), .start_pulse(start_pulse),
        .adc_srst(adc_srst), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_wreq) begin
                wreq_cnt++;
                if (exp_q.size() == 0) chk("tx_unexpected", exp_q.size(), 1);
                else chk("tx_byte", tx_wdata, exp_q.pop_front());
            end
            if (start_pulse) begin
                start_cnt++;
                chk("start_vs_wreq", tx_wreq, 0);
            end
            if (frame_err) ferr_cnt++;
            if (adc_srst) srst_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_vld  = 1'b1;
        @(posedge clk); #1;
        rx_vld  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [23:0] p, input logic [7:0] resp);
        exp_q.push_back(resp);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(p[23:16]);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
`ifdef CMD_CHECKSUM_EN
        send_byte(cmd ^ p[23:16] ^ p[15:8] ^ p[7:0]);
`endif
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_wreq"}, tx_wreq, 0);
        chk({tag, "_nowa"}, nowa_cfg, 0);
        chk({tag, "_nsamp"}, nsamp_cfg, 102400);
        chk({tag, "_calib"}, calib_ena, 0);
        chk({tag, "_start"}, start_pulse, 0);
        chk({tag, "_srst"}, adc_srst, 0);
        chk({tag, "_ferr"}, frame_err, 0);
    endtask

    initial begin
        int f0, w0, s0, n;
        repeat (3) @(posedge clk);
        check_reset_vals("rst");
        chk("rst_wdata", tx_wdata, 0);
        @(posedge clk); #1 rst = 1'b0;

        // SET_NOWA: upper bits beyond 9 ignored, then spec example
        send_frame(8'h01, 24'hFFFE00, 8'h81); wait_drain("nowa_hi_drain");
        chk("nowa_hi", nowa_cfg, 9'h000);
        send_frame(8'h01, 24'h00012C, 8'h81); wait_drain("nowa_drain");
        chk("nowa", nowa_cfg, 9'h12C);
        chk("nowa_ferr", ferr_cnt, 0);
        chk("wdata_hold", tx_wdata, 8'h81);

        // SET_NSAMP
        send_frame(8'h02, 24'h012345, 8'h82); wait_drain("nsamp1_drain");
        chk("nsamp1", nsamp_cfg, 18'h12345);
        send_frame(8'h02, 24'h019000, 8'h82); wait_drain("nsamp2_drain");
        chk("nsamp2", nsamp_cfg, 102400);
        send_frame(8'h02, 24'h000000, 8'hEE); wait_drain("nsamp0_drain");
        chk("nsamp0", nsamp_cfg, 102400);
        send_frame(8'h02, 24'hFC0000, 8'hEE); wait_drain("nsamp_hi_drain");
        chk("nsamp_hi", nsamp_cfg, 102400);
        busy = 1'b1;
        send_frame(8'h02, 24'h000010, 8'hEE); wait_drain("nsamp_busy_drain");
        chk("nsamp_busy", nsamp_cfg, 102400);
        busy = 1'b0;
        chk("nak_no_ferr", ferr_cnt, 0);

`ifdef CMD_CHECKSUM_EN
        exp_q.push_back(8'hEE);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hFF);
        wait_drain("chk_bad_drain");
        chk("chk_bad_calib", calib_ena, 0);
        chk("chk_bad_ferr", ferr_cnt, 1);
        ferr_cnt = 0;
`endif

        // CALIB
        send_frame(8'h03, 24'h000001, 8'h83); wait_drain("calib_drain");
        chk("calib_on", calib_ena, 1);
        busy = 1'b1;
        send_frame(8'h03, 24'h000000, 8'hEE); wait_drain("calib_busy_drain");
        chk("calib_busy", calib_ena, 1);
        busy = 1'b0;

        // START
        s0 = start_cnt;
        send_frame(8'h04, 24'h000000, 8'h84); wait_drain("start_drain");
        chk("start_once", start_cnt - s0, 1);
        busy = 1'b1;
        send_frame(8'h04, 24'h000000, 8'hEE); wait_drain("start_busy_drain");
        chk("start_busy", start_cnt - s0, 1);

        // SOFT_RST accepted while busy
        srst_cnt = 0;
        send_frame(8'h05, 24'h000000, 8'h85); wait_drain("srst_drain");
        repeat (30) @(posedge clk);
        chk("srst_len", srst_cnt, 16);
        busy = 1'b0;

        // tx_rdy low holds the response; bytes during RESP are dropped
        tx_rdy = 1'b0;
        w0 = wreq_cnt; f0 = ferr_cnt;
        send_frame(8'h01, 24'h000055, 8'h81);
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        repeat (100) @(posedge clk);
        chk("hold_no_wreq", wreq_cnt - w0, 0);
        chk("hold_pending", exp_q.size(), 1);
        tx_rdy = 1'b1;
        wait_drain("hold_drain");
        repeat (20) @(posedge clk);
        chk("resp_drop_wreq", wreq_cnt - w0, 1);
        chk("resp_drop_ferr", ferr_cnt - f0, 0);
        chk("hold_nowa", nowa_cfg, 9'h055);

        // Unknown command
        f0 = ferr_cnt;
        send_frame(8'h07, 24'h000000, 8'hEE); wait_drain("unk_drain");
        chk("unk_ferr", ferr_cnt - f0, 1);

        // Non-header noise in IDLE
        w0 = wreq_cnt;
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h01);
        repeat (20) @(posedge clk);
        chk("noise_silent", wreq_cnt - w0, 0);

        // Inter-byte timeout
        f0 = ferr_cnt; w0 = wreq_cnt;
        send_byte(8'hA5); send_byte(8'h01);
        n = 0;
        for (int i = 1; i <= 50100; i++) begin
            @(posedge clk); #1;
            if (frame_err) begin n = i; break; end
        end
        chk("tmo_cycles", (n >= 49998 && n <= 50001), 1);
        repeat (20) @(posedge clk);
        chk("tmo_ferr", ferr_cnt - f0, 1);
        chk("tmo_no_tx", wreq_cnt - w0, 0);
        send_frame(8'h01, 24'h0000AA, 8'h81); wait_drain("tmo_after_drain");
        chk("tmo_after", nowa_cfg, 9'h0AA);

        // Reset mid-frame
        w0 = wreq_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #1 rst = 1'b0;
        send_byte(8'h01); send_byte(8'h2C);
        repeat (20) @(posedge clk);
        chk("midrst_no_tx", wreq_cnt - w0, 0);
        send_frame(8'h01, 24'h000033, 8'h81); wait_drain("midrst_after_drain");
        chk("midrst_after", nowa_cfg, 9'h033);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
